load_store_unit: RTL and testbench

Load/store sequencer between the RV32I core datapath and the byte-wide data memory. Accepts one RV32I load or store per request (LB/LH/LW/LBU/LHU/SB/SH/SW). Breaks each access into 1, 2 or 4 little-endian byte transfers on the memory port, then assembles and sign/zero-extends load data. Reports completion with a one-cycle `Done` pulse.

---
 rtl/load_store_unit.sv | 98 +++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer over a byte-wide memory, 1/2/4 byte transfers per access.
// Optional alignment faulting is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  fault_o,
    output logic [31:0]           rdata_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_wd_o,
    input  logic [7:0]            mem_rd_i
);
    typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q, asm_q, asm_d, rdata_q, rdata_d;
    logic [2:0]            f3_q;
    logic                  we_q, fault_q, valid, misalign, reject, xfer, unused_addr;
    logic [1:0]            idx_q, last_q, last_d;
    assign unused_addr = ^addr_i;
    always_comb begin
        valid = we_i ? (funct3_i inside {3'b000, 3'b001, 3'b010})
                     : (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        last_d = funct3_i[1:0] == 2'b00 ? 2'd0 : funct3_i[1:0] == 2'b01 ? 2'd1 : 2'd3;
`ifdef LSU_ALIGN_CHECK_EN
        misalign = (funct3_i[1:0] == 2'b01 && addr_i[0]) || (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        reject = !valid || misalign;
    end
    // Incoming load byte merged into the assembly word so the final byte lands in RData on the FIN entry edge.
    always_comb begin
        asm_d = asm_q;
        asm_d[{idx_q, 3'b000} +: 8] = mem_rd_i;
        rdata_d = f3_q[1] ? asm_d
                : f3_q[0] ? {{16{!f3_q[2] && asm_d[15]}}, asm_d[15:0]}
                          : {{24{!f3_q[2] && asm_d[7]}}, asm_d[7:0]};
    end
    assign xfer     = state_q == XFER;
    assign ready_o  = state_q == IDLE;
    assign done_o   = state_q == FIN;
    assign fault_o  = done_o && fault_q;
    assign rdata_o  = rdata_q;
    // Reset gates the write strobe so an aborted store cannot commit its in-flight byte.
    assign mem_we_o = xfer && we_q && !rst_i;
    assign mem_a_o  = xfer ? addr_q + ADDR_WIDTH'(idx_q) : '0;
    assign mem_wd_o = (xfer && we_q) ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_i) begin
                    fault_q <= reject;
                    state_q <= reject ? FIN : XFER;
                    if (!reject) begin
                        addr_q  <= addr_i[ADDR_WIDTH-1:0];
                        wdata_q <= wdata_i;
                        f3_q    <= funct3_i;
                        we_q    <= we_i;
                        idx_q   <= '0;
                        last_q  <= last_d;
                        asm_q   <= '0;
                    end
                end
                XFER: begin
                    idx_q <= idx_q + 2'd1;
                    if (!we_q) asm_q <= asm_d;
                    if (idx_q == last_q) begin
                        state_q <= FIN;
                        if (!we_q) rdata_q <= rdata_d;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked against a byte-array memory model.
module tb_load_store_unit;
    logic        clk = 0, rst = 1, req = 0, we = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        ready, done, fault, mem_we;
    logic [31:0] rdata;
    logic [7:0]  mem_a, mem_wd, mem_rd;
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    bit          mem_init = 1;
    logic [31:0] rdata_exp = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign mem_rd = mem[mem_a];
    always @(posedge clk)
        if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        else if (mem_we) mem[mem_a] <= mem_wd;

    load_store_unit #(.ADDR_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(funct3),
        .addr_i(addr), .wdata_i(wdata), .ready_o(ready), .done_o(done),
        .fault_o(fault), .rdata_o(rdata), .mem_we_o(mem_we), .mem_a_o(mem_a),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    task automatic chk_byte(input logic [7:0] a, input logic [7:0] exp, input string nm);
        checks++;
        if (mem[a] !== exp) begin
            errors++;
            $display("FAIL %s mem[%02h] got %02h expected %02h", nm, a, mem[a], exp);
        end
    endtask

    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit busy, input string nm);
        int n, cyc, wes;
        bit flt, got, extra_done;
        logic [31:0] word, junk_a;
        n = f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
        flt = w ? !(f3 inside {0, 1, 2}) : !(f3 inside {0, 1, 2, 4, 5});
`ifdef LSU_ALIGN_CHECK_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 0)) flt = 1;
`endif
        if (!flt && w) for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
        if (!flt && !w) begin
            word = 0;
            for (int i = 0; i < n; i++) word |= 32'(ref_mem[8'(a + 32'(i))]) << (8 * i);
            if (!f3[2] && n < 4 && word >= (32'd1 << (8 * n - 1))) word = word - (32'd1 << (8 * n));
            rdata_exp = word;
        end
        junk_a = a + 128;
        @(negedge clk);
        req = 1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 0;
        cyc = 0; got = 0; wes = 0;
        while (cyc < 12 && !got) begin
            @(negedge clk);
            cyc++;
            if (busy && cyc == 1) begin
                req = 1; we = 1; funct3 = 0; addr = junk_a; wdata = $urandom;
            end
            if (mem_we) wes++;
            if (done) begin
                got = 1;
                req = 0;
                checks++;
                if (cyc != (flt ? 1 : n + 1)) begin
                    errors++; $display("FAIL %s latency got %0d expected %0d", nm, cyc, flt ? 1 : n + 1);
                end
                checks++;
                if (fault !== flt) begin
                    errors++; $display("FAIL %s fault got %0b expected %0b", nm, fault, flt);
                end
                checks++;
                if (rdata !== rdata_exp) begin
                    errors++; $display("FAIL %s rdata got %08h expected %08h", nm, rdata, rdata_exp);
                end
            end
        end
        req = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout no done within %0d cycles", nm, cyc);
        end
        checks++;
        if (wes != ((flt || !w) ? 0 : n)) begin
            errors++; $display("FAIL %s write strobes got %0d expected %0d", nm, wes, (flt || !w) ? 0 : n);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1 || done !== 0 || mem_we !== 0 || mem_a !== 0) begin
            errors++; $display("FAIL %s idle ready=%0b done=%0b we=%0b a=%02h expected 1 0 0 00", nm, ready, done, mem_we, mem_a);
        end
        for (int i = 0; i < 4; i++) chk_byte(8'(a + 32'(i)), ref_mem[8'(a + 32'(i))], nm);
        if (busy) begin
            extra_done = 0;
            repeat (4) begin @(negedge clk); if (done) extra_done = 1; end
            checks++;
            if (extra_done) begin
                errors++; $display("FAIL %s busy request got done expected none", nm);
            end
            chk_byte(8'(junk_a), ref_mem[8'(junk_a)], {nm, "_busy"});
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1 || done !== 0 || fault !== 0 || rdata !== 0 || mem_we !== 0 || mem_a !== 0 || mem_wd !== 0) begin
            errors++;
            $display("FAIL reset ready=%0b done=%0b fault=%0b rdata=%08h we=%0b a=%02h wd=%02h expected 1 0 0 0 0 0 0",
                     ready, done, fault, rdata, mem_we, mem_a, mem_wd);
        end
        rst = 0; mem_init = 0;
    endtask

    task automatic test_sw_lw;
        access(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw");
        chk_byte(8'h10, 8'hEF, "sw_b0"); chk_byte(8'h11, 8'hBE, "sw_b1");
        chk_byte(8'h12, 8'hAD, "sw_b2"); chk_byte(8'h13, 8'hDE, "sw_b3");
        access(0, 3'b010, 32'h10, 0, 0, "lw");
        checks++;
        if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw rdata got %08h expected deadbeef", rdata); end
    endtask

    task automatic test_extension;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [4] = '{32'h10, 32'h10, 32'h12, 32'h12};
        logic [31:0] exps[4] = '{32'hFFFFFFEF, 32'h000000EF, 32'hFFFFDEAD, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            access(0, f3s[i], as[i], 0, 0, "ext");
            checks++;
            if (rdata !== exps[i]) begin errors++; $display("FAIL ext%0d rdata got %08h expected %08h", i, rdata, exps[i]); end
        end
    endtask

    task automatic test_align_invalid;
        access(1, 3'b001, 32'h11, 32'h1234, 0, "sh_odd");
`ifndef LSU_ALIGN_CHECK_EN
        chk_byte(8'h11, 8'h34, "sh_odd_b0"); chk_byte(8'h12, 8'h12, "sh_odd_b1");
`endif
        access(0, 3'b011, 32'h40, 0, 0, "ld_inv");
        access(1, 3'b100, 32'h44, 32'h55667788, 0, "st_inv");
    endtask

    task automatic test_wrap_busy;
        access(1, 3'b010, 32'h1FE, 32'h44332211, 1, "wrap");
`ifndef LSU_ALIGN_CHECK_EN
        chk_byte(8'hFE, 8'h11, "wrap_fe"); chk_byte(8'hFF, 8'h22, "wrap_ff");
        chk_byte(8'h00, 8'h33, "wrap_00"); chk_byte(8'h01, 8'h44, "wrap_01");
`endif
        access(0, 3'b010, 32'h1FE, 0, 1, "wrap_lw");
    endtask

    task automatic test_reset_mid_store;
        logic [7:0] old22, old23;
        bit saw_done;
        old22 = mem[8'h22]; old23 = mem[8'h23];
        @(negedge clk);
        req = 1; we = 1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if (ready !== 1 || rdata !== 0) begin errors++; $display("FAIL rst_mid ready=%0b rdata=%08h expected 1 0", ready, rdata); end
        saw_done = done;
        repeat (4) begin @(negedge clk); if (done) saw_done = 1; end
        checks++;
        if (saw_done) begin errors++; $display("FAIL rst_mid done got 1 expected 0"); end
        chk_byte(8'h20, 8'hDD, "rst_mid_20"); chk_byte(8'h21, 8'hCC, "rst_mid_21");
        chk_byte(8'h22, old22, "rst_mid_22"); chk_byte(8'h23, old23, "rst_mid_23");
        ref_mem[8'h20] = 8'hDD; ref_mem[8'h21] = 8'hCC;
        rdata_exp = 0;
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++)
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, 3) == 0, "rand");
        for (int i = 0; i < 256; i++) chk_byte(8'(i), ref_mem[i], "final_mem");
    endtask

    initial begin
        test_reset;
        test_sw_lw;
        test_extension;
        test_align_invalid;
        test_wrap_busy;
        test_reset_mid_store;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
